sram_rw_port_ctrl: RTL
======================

Name: sram_rw_port_ctrl

Overview:
- Front-end controller for one single-port RW0 SRAM macro (data/tag array class: 1-cycle read latency, registered read address, per-lane write mask).
- Accepts read/write requests over a valid/ready channel, drives the macro's RW0 pins, captures read data exactly one cycle after issue, and returns it over a backpressured response channel via a small response FIFO.
- Sits between cache pipeline logic and the array macro.

Parameters:
- ADDR_W, 8, macro address width.
- DATA_W, 64, macro data width.
- MASK_W, 8, write-mask lanes; DATA_W divisible by MASK_W.
- RESP_DEPTH, 2, response FIFO entries (>=2).

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when valid&ready.
- req_write  in  1  1=write, 0=read.
- req_addr  in  ADDR_W  request address.
- req_wmask  in  MASK_W  write lane mask (ignored on read).
- req_wdata  in  DATA_W  write data.
- resp_valid  out  1  read data available.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  DATA_W  read data, in request order.
- sram_addr  out  ADDR_W  to macro RW0_addr.
- sram_en  out  1  to RW0_en.
- sram_wmode  out  1  to RW0_wmode.
- sram_wmask  out  MASK_W  to RW0_wmask.
- sram_wdata  out  DATA_W  to RW0_wdata.
- sram_rdata  in  DATA_W  from RW0_rdata.

Behaviour:
- Reset: req_ready=0, resp_valid=0, resp_rdata=0, sram_en=0, in-flight flag cleared, FIFO emptied (ptrs/count=0). Reset mid-operation discards the in-flight read and all queued responses; no response is produced for them.
- Issue (cycle N, fire=req_valid&req_ready): sram_en=fire, sram_wmode=req_write, sram_addr/wmask/wdata driven combinationally from the request. sram_wmask=0 on reads.
- Writes: always accepted when not in reset (req_ready=1 if req_write). No response.
- Reads: accepted iff count + inflight - pop < RESP_DEPTH, where pop=resp_valid&resp_ready. This is a combinational path from resp_ready to req_ready.
- Read latency: inflight set at end of N. sram_rdata is sampled at end of N+1 and pushed to the FIFO. resp_valid is asserted from N+2 with a registered output.
- Throughput: back-to-back reads at 1/cycle sustained while resp_ready=1.
- Write at N+1 to the address read at N: the captured value is the pre-write data (capture edge coincides with write edge).
- Simultaneous push and pop at full: legal, count unchanged.
- Pointers wrap modulo RESP_DEPTH.
- resp_rdata and resp_valid are held stable while resp_valid & !resp_ready.
- When sram_en=0, sram_addr/wdata are don't-care but must not be X (hold last values).

Optional Feature:
- SRAM_RW_PORT_STATS_EN defined: adds outputs stat_reads, stat_writes, stat_stalls (32-bit each, reset 0, saturating).
  - stat_reads / stat_writes count read and write fires.
  - stat_stalls counts cycles with req_valid & !req_ready.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package sram_rw_port_pkg: default width constants, a req_t struct (write, addr, wmask, wdata), and function clog2-based pointer width.
- One sub-module: sram_resp_fifo (RESP_DEPTH x DATA_W, push/pop/count, synchronous active-high reset).

Test Plan:
- Write addr 0x10, data 0x1122334455667788, mask 0xFF; then read 0x10 -> sram_en/wmode pulses correct; resp_rdata=0x1122334455667788 with resp_valid exactly 2 cycles after read fire.
- Byte mask: write 0xFFFF... mask 0xFF, then write 0x0 mask 0x0F to the same address, read -> 0xFFFFFFFF00000000.
- Streaming: 16 consecutive reads, resp_ready=1 -> req_ready stays 1; 16 in-order responses at 1/cycle.
- Backpressure: resp_ready=0, issue 4 reads -> only 2 accepted (RESP_DEPTH=2), req_ready=0 afterwards, resp_rdata stable. Raise resp_ready -> drains in order, next read accepted in the same cycle as the pop.
- Read 0x20 (old 0xAA..), write 0x20=0x55.. in the next cycle -> response is 0xAA..; subsequent read returns 0x55...
- Assert reset with 1 read in flight and 1 queued -> resp_valid=0 the cycle after reset, no stale response after release. With SRAM_RW_PORT_STATS_EN, counters read 0.

Source files
------------

// File: rtl/sram_rw_port_pkg.sv
// Shared widths, request bundle and pointer sizing for the RW0 port controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sram_rw_port_pkg;

  localparam int DEF_ADDR_W     = 8;
  localparam int DEF_DATA_W     = 64;
  localparam int DEF_MASK_W     = 8;
  localparam int DEF_RESP_DEPTH = 2;

  // Request bundle at the default widths.
  typedef struct packed {
    logic                  write;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_MASK_W-1:0] wmask;
    logic [DEF_DATA_W-1:0] wdata;
  } req_t;

  // Pointer width for a circular buffer; a 1-entry buffer still needs one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sram_resp_fifo.sv
// Response FIFO holding captured read data until the consumer takes it.
// Latency: push visible at pop_data/count the cycle after the push edge.
// Backpressure: none internally; the caller never pushes when full unless also popping.
// Ports: clock/reset (sync, active-high), push/push_data, pop, pop_data (head), count.
module sram_resp_fifo
  import sram_rw_port_pkg::*;
#(
  parameter int DEPTH  = DEF_RESP_DEPTH,
  parameter int DATA_W = DEF_DATA_W,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = ptr_w(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // Head entry is never overwritten while occupied: at full, the write slot
  // equals the head only when the head is being popped on the same edge.
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_rw_port_ctrl.sv
// Front-end for a single-port RW0 SRAM: issues reads/writes, captures read data, queues responses.
// Latency: request drives the macro combinationally; read response valid 2 cycles after fire.
// Backpressure: writes always accepted; reads accepted only when a FIFO slot is guaranteed.
// Ports: clock/reset (sync, active-high); req_* valid/ready request channel; resp_* valid/ready
// response channel; sram_* to/from the macro RW0 pins. Optional stat_reads/stat_writes/
// stat_stalls counters exist only when SRAM_RW_PORT_STATS_EN is defined.
module sram_rw_port_ctrl
  import sram_rw_port_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MASK_W     = DEF_MASK_W,
  parameter int RESP_DEPTH = DEF_RESP_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [MASK_W-1:0] req_wmask,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [MASK_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
`ifdef SRAM_RW_PORT_STATS_EN
  ,
  output logic [31:0]       stat_reads,
  output logic [31:0]       stat_writes,
  output logic [31:0]       stat_stalls
`endif
);

  localparam int CNT_W = $clog2(RESP_DEPTH + 1);

  logic              inflight;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    occ;
  logic              pop;
  logic              rd_ok;
  logic              fire;
  logic              rd_fire;
  logic              wr_fire;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] last_wdata;

  assign resp_valid = (count != '0);
  assign pop        = resp_valid & resp_ready;

  // Slots committed after this edge: queued + the read still in the macro,
  // minus the one leaving now. A pop frees its slot for a read in the same cycle.
  assign occ   = {1'b0, count} + (CNT_W + 1)'(inflight) - (CNT_W + 1)'(pop);
  assign rd_ok = (occ < (CNT_W + 1)'(RESP_DEPTH));

  assign req_ready = !reset && (req_write || rd_ok);
  assign fire      = req_valid & req_ready;
  assign rd_fire   = fire & !req_write;
  assign wr_fire   = fire & req_write;

  // Idle cycles replay the last issued address/data so the pins never float to X.
  assign sram_en    = fire;
  assign sram_wmode = wr_fire;
  assign sram_wmask = wr_fire ? req_wmask : '0;
  assign sram_addr  = fire ? req_addr : last_addr;
  assign sram_wdata = fire ? req_wdata : last_wdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      inflight   <= 1'b0;
      last_addr  <= '0;
      last_wdata <= '0;
    end else begin
      inflight <= rd_fire;
      if (fire) begin
        last_addr  <= req_addr;
        last_wdata <= req_wdata;
      end
    end
  end

  // Macro data is valid the cycle after issue; capture it on that edge.
  sram_resp_fifo #(
    .DEPTH  (RESP_DEPTH),
    .DATA_W (DATA_W)
  ) u_resp_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (inflight),
    .push_data (sram_rdata),
    .pop       (pop),
    .pop_data  (resp_rdata),
    .count     (count)
  );

`ifdef SRAM_RW_PORT_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_reads  <= '0;
      stat_writes <= '0;
      stat_stalls <= '0;
    end else begin
      if (rd_fire && stat_reads != '1) begin
        stat_reads <= stat_reads + 32'd1;
      end
      if (wr_fire && stat_writes != '1) begin
        stat_writes <= stat_writes + 32'd1;
      end
      if (req_valid && !req_ready && stat_stalls != '1) begin
        stat_stalls <= stat_stalls + 32'd1;
      end
    end
  end
`endif

endmodule
